// File: rtl/alu_mul_sequencer.sv
// Multi-cycle unsigned W x W multiply (low word) that borrows the EX-stage ALU,
// running MSB-first shift-and-add using only the ALU's DOUBLE and ADD operations.
module alu_mul_sequencer #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         flush,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    input  logic [W-1:0] alu_result,
    output logic         alu_sel,
    output logic [3:0]   alu_ctrl,
    output logic [W-1:0] alu_in_a,
    output logic [W-1:0] alu_in_b,
    output logic         stall,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [3:0] CTRL_DBL = 4'b0100;
    localparam logic [3:0] CTRL_ADD = 4'b0010;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DBL,
        S_ADD,
        S_DONE
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [W-1:0]   acc;
    logic [W-1:0]   acc_nxt;
    logic [W-1:0]   a_q;
    logic [W-1:0]   a_nxt;
    logic [W-1:0]   b_q;
    logic [W-1:0]   b_nxt;
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  cnt_nxt;
    logic [W-1:0]   result_nxt;
    logic           done_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            acc    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            cnt    <= '0;
            result <= '0;
            done   <= 1'b0;
        end else begin
            state  <= state_nxt;
            acc    <= acc_nxt;
            a_q    <= a_nxt;
            b_q    <= b_nxt;
            cnt    <= cnt_nxt;
            result <= result_nxt;
            done   <= done_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        acc_nxt    = acc;
        a_nxt      = a_q;
        b_nxt      = b_q;
        cnt_nxt    = cnt;
        result_nxt = result;
        done_nxt   = 1'b0;
        alu_sel    = 1'b0;
        alu_ctrl   = 4'b0000;
        alu_in_a   = '0;
        alu_in_b   = '0;
        stall      = 1'b0;
        busy       = (state != S_IDLE);

        case (state)
            S_IDLE: begin
                // Stall combinationally so the issuing instruction stays in EX.
                stall = start & ~flush;
                if (start && !flush) begin
                    a_nxt     = op_a;
                    b_nxt     = op_b;
                    acc_nxt   = '0;
                    cnt_nxt   = CW'(W - 1);
                    state_nxt = S_DBL;
                end
            end
            S_DBL: begin
                alu_sel  = 1'b1;
                alu_ctrl = CTRL_DBL;
                alu_in_a = acc;
                stall    = 1'b1;
                acc_nxt  = alu_result;
                // cnt is kept when the bit is set; the ADD step consumes it.
                if (b_q[cnt]) begin
                    state_nxt = S_ADD;
                end else if (cnt == '0) begin
                    state_nxt = S_DONE;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            S_ADD: begin
                alu_sel  = 1'b1;
                alu_ctrl = CTRL_ADD;
                alu_in_a = acc;
                alu_in_b = a_q;
                stall    = 1'b1;
                acc_nxt  = alu_result;
                if (cnt == '0) begin
                    state_nxt = S_DONE;
                end else begin
                    cnt_nxt   = cnt - CW'(1);
                    state_nxt = S_DBL;
                end
            end
            S_DONE: begin
                done_nxt   = 1'b1;
                result_nxt = acc;
                state_nxt  = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // An abort drops the multiply without a done pulse or result update.
        if (flush && state != S_IDLE) begin
            state_nxt  = S_IDLE;
            done_nxt   = 1'b0;
            result_nxt = result;
        end
    end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Self-checking bench for alu_mul_sequencer: combinational ALU model, table-driven
// multiplies checked against plain arithmetic, plus flush/reset/back-to-back sequences.
module tb_alu_mul_sequencer;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         flush;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic [W-1:0] alu_result;
    logic         alu_sel;
    logic [3:0]   alu_ctrl;
    logic [W-1:0] alu_in_a;
    logic [W-1:0] alu_in_b;
    logic         stall;
    logic         busy;
    logic         done;
    logic [W-1:0] result;

    int n_checks = 0;
    int n_fail   = 0;

    alu_mul_sequencer #(.W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .flush      (flush),
        .op_a       (op_a),
        .op_b       (op_b),
        .alu_result (alu_result),
        .alu_sel    (alu_sel),
        .alu_ctrl   (alu_ctrl),
        .alu_in_a   (alu_in_a),
        .alu_in_b   (alu_in_b),
        .stall      (stall),
        .busy       (busy),
        .done       (done),
        .result     (result)
    );

    // Shared EX-stage ALU: DOUBLE and ADD are all the sequencer may use.
    assign alu_result = (alu_ctrl == 4'b0100) ? alu_in_a + alu_in_a :
                        (alu_ctrl == 4'b0010) ? alu_in_a + alu_in_b : '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_res;
        int           exp_cyc;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            start = 1'b0;
            flush = 1'b0;
        end
    endtask

    // Drives one multiply starting in the current cycle (cycle 0) and follows it
    // until done or the cycle budget runs out. Inputs for cycle k are applied at
    // its falling edge and outputs are sampled 1 time unit later.
    task automatic run_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] exp_res, input int exp_cyc,
                           input int flush_cyc, input int inj_cyc, input int rst_cyc,
                           input string tag);
        int           cyc;
        int           n_dbl;
        int           n_add;
        int           own_err;
        int           done_cyc;
        bit           seen;
        bit           aborted;
        int           limit;
        logic [W-1:0] res_at_done;

        aborted  = (flush_cyc >= 0) || (rst_cyc >= 0);
        limit    = aborted ? 2 * W + 10 : exp_cyc + 5;
        n_dbl    = 0;
        n_add    = 0;
        own_err  = 0;
        done_cyc = -1;
        seen     = 1'b0;
        res_at_done = '0;

        start = 1'b1;
        flush = 1'b0;
        op_a  = a;
        op_b  = b;
        #1;
        check({tag, " start cycle stall/alu_sel/busy"}, {61'd0, stall, alu_sel, busy}, 64'b100);

        cyc = 0;
        while (!seen && cyc < limit) begin
            @(negedge clk);
            cyc++;
            start = (cyc == inj_cyc);
            if (cyc == inj_cyc) begin
                op_a = 32'd1;
                op_b = 32'd1;
            end
            flush = (cyc == flush_cyc);
            if (rst_cyc >= 0)
                rst_n = !(cyc >= rst_cyc && cyc < rst_cyc + 3);
            #1;
            if (done) begin
                seen        = 1'b1;
                done_cyc    = cyc;
                res_at_done = result;
            end
            if (alu_sel) begin
                if (alu_ctrl == 4'b0100) n_dbl++;
                else if (alu_ctrl == 4'b0010) n_add++;
                else own_err++;
            end else if (alu_ctrl != 4'b0000 || alu_in_a != '0 || alu_in_b != '0) begin
                own_err++;
            end
            if (stall !== alu_sel) own_err++;
            if (!aborted && busy !== (cyc < exp_cyc)) own_err++;
            if (flush_cyc >= 0 && cyc == flush_cyc + 1)
                check({tag, " after flush busy/alu_sel/stall"}, {61'd0, busy, alu_sel, stall}, 64'd0);
            if (cyc == rst_cyc) begin
                check({tag, " in reset ctrl outputs"},
                      {56'd0, alu_sel, stall, busy, done, alu_ctrl}, 64'd0);
                check({tag, " in reset data outputs"},
                      {32'd0, result | alu_in_a | alu_in_b}, 64'd0);
            end
        end

        if (aborted) begin
            check({tag, " no done pulse"}, {63'd0, seen}, 64'd0);
            check({tag, " result kept"}, {32'd0, result}, {32'd0, exp_res});
            check({tag, " ownership"}, own_err, 0);
        end else begin
            check({tag, " done cycle"}, done_cyc, exp_cyc);
            check({tag, " result"}, {32'd0, res_at_done}, {32'd0, exp_res});
            check({tag, " DBL count"}, n_dbl, W);
            check({tag, " ADD count"}, n_add, $countones(b));
            check({tag, " ownership/stall/busy"}, own_err, 0);
        end
        start = 1'b0;
        flush = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        flush = 1'b0;
        op_a  = '0;
        op_b  = '0;

        // Directed vectors with hand-derived expectations, then random ones from the model.
        vecs[0] = '{a: 32'd6,         b: 32'd7,         exp_res: 32'd42,         exp_cyc: 37};
        vecs[1] = '{a: 32'd5,         b: 32'd0,         exp_res: 32'd0,          exp_cyc: 34};
        vecs[2] = '{a: 32'hFFFFFFFF,  b: 32'hFFFFFFFF,  exp_res: 32'h00000001,   exp_cyc: 66};
        vecs[3] = '{a: 32'd0,         b: 32'h80000001,  exp_res: 32'd0,          exp_cyc: 36};
        for (int i = 4; i < 12; i++) begin
            vecs[i].a       = $urandom;
            vecs[i].b       = (i == 11) ? ($urandom & 32'h0000FFFF) : $urandom;
            vecs[i].exp_res = vecs[i].a * vecs[i].b;
            vecs[i].exp_cyc = W + $countones(vecs[i].b) + 2;
        end

        #1;
        check("reset ctrl outputs", {56'd0, alu_sel, stall, busy, done, alu_ctrl}, 64'd0);
        check("reset result", {32'd0, result}, 64'd0);
        idle(3);
        rst_n = 1'b1;
        idle(2);

        for (int i = 0; i < 12; i++) begin
            run_mul(vecs[i].a, vecs[i].b, vecs[i].exp_res, vecs[i].exp_cyc,
                    -1, -1, -1, $sformatf("vec%0d", i));
            idle(2);
        end

        // Basic product again, then confirm done is a single pulse and result holds.
        run_mul(32'd6, 32'd7, 32'd42, 37, -1, -1, -1, "basic");
        @(negedge clk);
        #1;
        check("done single pulse", {63'd0, done}, 64'd0);
        check("result held", {32'd0, result}, 64'd42);
        idle(2);

        // Flush mid-run: no done, prior result kept.
        run_mul(32'd9, 32'd9, 32'd42, 0, 5, -1, -1, "flush");
        idle(2);

        // start while busy is ignored; start in the done cycle is accepted.
        run_mul(32'd6, 32'd7, 32'd42, 37, -1, 3, -1, "busy_start");
        run_mul(32'd2, 32'd3, 32'd6, W + 2 + 2, -1, -1, -1, "back_to_back");
        idle(2);

        // Asynchronous reset mid-run discards the multiply and clears result.
        run_mul(32'd3, 32'd5, 32'd0, 0, -1, -1, 10, "reset_mid");
        idle(2);
        run_mul(32'd3, 32'd5, 32'd15, W + 2 + 2, -1, -1, -1, "after_reset");
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_mul_sequencer.md
Name: alu_mul_sequencer

Overview:
- Multi-cycle sequencer that borrows the EX-stage ALU to run an unsigned 32x32 multiply (low word) as MSB-first shift-and-add.
- Issues only the existing ALU operations: DOUBLE (4'b0100) and ADD (4'b0010).
- Sits beside the EX stage. Stalls the pipeline while it owns the ALU, muxes its own operands and control code onto the ALU, and returns the product with a one-cycle done pulse.

Parameters:
W, 32, operand/result width; counter width is clog2(W).

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
start  in  1  request from EX stage; sampled only in IDLE
flush  in  1  synchronous abort (branch mispredict/trap)
op_a  in  W  multiplicand, captured on start acceptance
op_b  in  W  multiplier, captured on start acceptance
alu_result  in  W  result from shared ALU, same cycle (combinational ALU)
alu_sel  out  1  1 = sequencer drives ALU inputs/control; 0 = pipeline drives
alu_ctrl  out  4  ALU control code while alu_sel=1; 4'b0000 otherwise
alu_in_a  out  W  ALU operand A while alu_sel=1; 0 otherwise
alu_in_b  out  W  ALU operand B while alu_sel=1; 0 otherwise
stall  out  1  hold IF/ID/EX pipeline registers
busy  out  1  state != IDLE
done  out  1  one-cycle pulse, result valid
result  out  W  low W bits of op_a*op_b; held until next accepted start

Behaviour:
Reset (rst_n low, any time, async):
- state=IDLE; acc, a_q, b_q, cnt, result = 0.
- done=0, busy=0, alu_sel=0, stall=0.
- A multiply in flight is discarded with no done pulse.

State machine (IDLE, DBL, ADD, DONE):
- IDLE:
  - alu_sel=0; stall = start & ~flush (combinational, so the issuing instruction is held).
  - On start & ~flush: a_q<=op_a, b_q<=op_b, acc<=0, cnt<=W-1; go to DBL.
- DBL:
  - alu_sel=1, alu_ctrl=0100, alu_in_a=acc, alu_in_b=0; acc<=alu_result.
  - If b_q[cnt]=1, go to ADD.
  - Else if cnt==0, go to DONE.
  - Else cnt<=cnt-1, stay in DBL.
- ADD:
  - alu_sel=1, alu_ctrl=0010, alu_in_a=acc, alu_in_b=a_q; acc<=alu_result.
  - If cnt==0, go to DONE.
  - Else cnt<=cnt-1, go to DBL.
- DONE:
  - alu_sel=0, stall=0, done=1, result<=acc (result visible the cycle after DONE; done and result share that cycle via registered done).
  - Go to IDLE.
  - Exact timing: DONE registers result and done; both are high/valid in the first IDLE cycle after DONE.

Stall and busy:
- stall=1 in DBL and ADD.
- busy=1 in DBL, ADD, DONE.

Arithmetic:
- Modular W-bit; overflow bits are dropped silently.
- No signed handling; signed variants are out of scope.

Latency:
- Start accepted in cycle 0; DBL entered in cycle 1.
- done is high in cycle W + popcount(op_b) + 2.
- op_b=0 takes W+2 cycles; op_b=all-ones takes 2W+2 cycles.

Boundary conditions:
- start while busy: ignored; no queueing.
- start and flush in the same IDLE cycle: not accepted, stall=0.
- flush in DBL/ADD/DONE: go to IDLE next cycle, no done pulse, result unchanged, alu_sel=0 next cycle.
- start in the same cycle done is high: accepted normally (state is IDLE).
- op_a=0 or op_b=0: full sequence still runs; result=0.
- alu_ctrl never carries 0110, 0000 or 0001 while alu_sel=1.

Test Plan:
- Reset mid-run: start a=3,b=5, drop rst_n at cycle 10 -> all outputs 0 immediately, no done pulse, result=0 after release.
- Basic: a=6, b=7 -> done high exactly in cycle 37, result=42, stall high cycles 1..35, ALU sees 32 DBL + 3 ADD codes.
- Zero and wrap: a=5, b=0 -> done at cycle 34, result=0. a=b=32'hFFFFFFFF -> done at cycle 66, result=32'h00000001.
- Flush: a=9, b=9, assert flush at cycle 5 -> IDLE at cycle 6, no done, result keeps prior value (42), stall low from cycle 6.
- Busy-start/back-to-back: pulse start with a=1, b=1 at cycle 3 while running -> ignored. Then assert start with a=2, b=3 in the done cycle -> accepted, second done with result=6 after a further W+2+2 cycles.
- Ownership: alu_sel=0 and alu_ctrl=0 in every IDLE/DONE cycle; stall=1 in exactly the cycles where alu_sel=1, plus the start cycle.
